// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between I-cache and D-cache,
// one transaction in flight, with a watchdog that aborts hung memory transactions.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              ireq_ready,
  output logic              irsp_valid,
  output logic [LINE_W-1:0] irsp_data,
  input  logic              dreq_valid,
  input  logic              dreq_write,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [LINE_W-1:0] dreq_wdata,
  output logic              dreq_ready,
  output logic              drsp_valid,
  output logic [LINE_W-1:0] drsp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q;
  logic        last_d_q;
  logic        own_d_q;
  logic [15:0] cnt_q;
  logic        grant_d;
  // D wins when alone, or on a tie when I was served last
  assign grant_d = dreq_valid && (!ireq_valid || !last_d_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      own_d_q     <= 1'b0;
      cnt_q       <= '0;
      ireq_ready  <= 1'b0;
      irsp_valid  <= 1'b0;
      irsp_data   <= '0;
      dreq_ready  <= 1'b0;
      drsp_valid  <= 1'b0;
      drsp_data   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ireq_ready  <= 1'b0;
      dreq_ready  <= 1'b0;
      irsp_valid  <= 1'b0;
      drsp_valid  <= 1'b0;
      timeout_err <= 1'b0;
      if (state_q == IDLE) begin
        if (ireq_valid || dreq_valid) begin
          state_q    <= BUSY;
          busy       <= 1'b1;
          mem_req    <= 1'b1;
          own_d_q    <= grant_d;
          last_d_q   <= grant_d;
          cnt_q      <= '0;
          mem_we     <= grant_d && dreq_write;
          mem_addr   <= grant_d ? dreq_addr : ireq_addr;
          mem_wdata  <= grant_d ? dreq_wdata : mem_wdata;
          ireq_ready <= !grant_d;
          dreq_ready <= grant_d;
        end
      end else if (mem_ack || cnt_q == 16'(TIMEOUT_CYC - 1)) begin
        // ack has priority over the watchdog on the same edge
        state_q     <= IDLE;
        busy        <= 1'b0;
        mem_req     <= 1'b0;
        timeout_err <= !mem_ack;
        if (own_d_q) begin
          drsp_valid <= 1'b1;
          drsp_data  <= (mem_ack && !mem_we) ? mem_rdata : '0;
        end else begin
          irsp_valid <= 1'b1;
          irsp_data  <= mem_ack ? mem_rdata : '0;
        end
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, transaction-level reference model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 4;
  localparam logic [LW-1:0] RD = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ireq_valid = 1'b0;
  logic [AW-1:0] ireq_addr = '0;
  logic          dreq_valid = 1'b0;
  logic          dreq_write = 1'b0;
  logic [AW-1:0] dreq_addr = '0;
  logic [LW-1:0] dreq_wdata = '0;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  logic          ireq_ready, irsp_valid, dreq_ready, drsp_valid;
  logic          mem_req, mem_we, busy, timeout_err;
  logic [LW-1:0] irsp_data, drsp_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .irsp_valid(irsp_valid), .irsp_data(irsp_data),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
    .drsp_valid(drsp_valid), .drsp_data(drsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, tracked by owner and waited cycles
  bit            m_busy = 1'b0;
  bit            m_own_d = 1'b0;
  bit            m_last_d = 1'b1;
  int            m_waited = 0;
  logic          e_ir = 1'b0, e_dr = 1'b0, e_iv = 1'b0, e_dv = 1'b0, e_to = 1'b0;
  logic          e_req = 1'b0, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [LW-1:0] e_wdata = '0, e_idata = '0, e_ddata = '0;

  task automatic finish_txn(input logic [LW-1:0] data, input bit aborted);
    m_busy = 1'b0;
    e_req  = 1'b0;
    e_to   = aborted;
    if (m_own_d) begin e_dv = 1'b1; e_ddata = data; end
    else begin e_iv = 1'b1; e_idata = data; end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_last_d = 1'b1; m_waited = 0;
      e_ir = 1'b0; e_dr = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_to = 1'b0;
      e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_idata = '0; e_ddata = '0;
    end else begin
      e_ir = 1'b0; e_dr = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_to = 1'b0;
      if (!m_busy) begin
        if (ireq_valid || dreq_valid) begin
          m_own_d  = ireq_valid ? (dreq_valid && !m_last_d) : 1'b1;
          m_last_d = m_own_d;
          m_busy   = 1'b1;
          m_waited = 0;
          e_req    = 1'b1;
          e_we     = m_own_d && dreq_write;
          e_addr   = m_own_d ? dreq_addr : ireq_addr;
          if (m_own_d) e_wdata = dreq_wdata;
          e_ir = !m_own_d;
          e_dr = m_own_d;
        end
      end else if (mem_ack) begin
        finish_txn((m_own_d && e_we) ? '0 : mem_rdata, 1'b0);
      end else begin
        m_waited++;
        if (m_waited == TO) finish_txn('0, 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("ireq_ready", LW'(ireq_ready), LW'(e_ir));
      chk("dreq_ready", LW'(dreq_ready), LW'(e_dr));
      chk("one_ready", LW'(ireq_ready && dreq_ready), '0);
      chk("irsp_valid", LW'(irsp_valid), LW'(e_iv));
      chk("drsp_valid", LW'(drsp_valid), LW'(e_dv));
      chk("irsp_data", irsp_data, e_idata);
      chk("drsp_data", drsp_data, e_ddata);
      chk("mem_req", LW'(mem_req), LW'(e_req));
      chk("busy", LW'(busy), LW'(m_busy));
      chk("timeout_err", LW'(timeout_err), LW'(e_to));
      if (e_req) begin
        chk("mem_we", LW'(mem_we), LW'(e_we));
        chk("mem_addr", LW'(mem_addr), LW'(e_addr));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string order;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // reset while a transaction is in flight
    @(negedge clk); ireq_valid = 1'b1; ireq_addr = 32'h0000_3000;
    @(negedge clk); ireq_valid = 1'b0;
    chk("rst_pre_busy", LW'(busy), LW'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", LW'(busy), '0);
    chk("rst_mem_req", LW'(mem_req), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_pulses", LW'({ireq_ready, dreq_ready, irsp_valid, drsp_valid, timeout_err}), '0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_rsp", LW'(irsp_valid), '0);
    chk("rst_idle", LW'(busy), '0);
    // single I read, ack three cycles after grant
    ireq_valid = 1'b1; ireq_addr = 32'h0000_1040;
    @(negedge clk); ireq_valid = 1'b0;
    chk("i_ready", LW'(ireq_ready), LW'(1'b1));
    chk("i_mem_we", LW'(mem_we), '0);
    chk("i_mem_addr", LW'(mem_addr), LW'(32'h0000_1040));
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = RD;
    @(negedge clk); mem_ack = 1'b0;
    chk("i_rsp_valid", LW'(irsp_valid), LW'(1'b1));
    chk("i_rsp_data", irsp_data, RD);
    @(negedge clk);
    chk("i_rsp_pulse", LW'(irsp_valid), '0);
    chk("i_rsp_hold", irsp_data, RD);
    // D write-through
    dreq_valid = 1'b1; dreq_write = 1'b1; dreq_addr = 32'h0000_2000; dreq_wdata = {16{8'h55}};
    @(negedge clk); dreq_valid = 1'b0;
    chk("d_ready", LW'(dreq_ready), LW'(1'b1));
    chk("d_mem_we", LW'(mem_we), LW'(1'b1));
    chk("d_mem_addr", LW'(mem_addr), LW'(32'h0000_2000));
    chk("d_mem_wdata", mem_wdata, {16{8'h55}});
    mem_ack = 1'b1; mem_rdata = ~RD;
    @(negedge clk); mem_ack = 1'b0; dreq_write = 1'b0;
    chk("d_rsp_valid", LW'(drsp_valid), LW'(1'b1));
    chk("d_rsp_data", drsp_data, '0);
    // stray ack while idle
    @(negedge clk); mem_ack = 1'b1; mem_rdata = RD;
    @(negedge clk); mem_ack = 1'b0;
    chk("stray_busy", LW'(busy), '0);
    chk("stray_rsp", LW'({irsp_valid, drsp_valid, mem_req}), '0);
    // contention from reset, ack one cycle after each grant
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    ireq_valid = 1'b1; dreq_valid = 1'b1; ireq_addr = 32'h0000_5000; dreq_addr = 32'h0000_6000;
    order = "";
    for (int g = 0; g < 4; g++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!(ireq_ready || dreq_ready) && w < 10) begin @(negedge clk); w++; end
      order = {order, ireq_ready ? "I" : dreq_ready ? "D" : "-"};
      mem_ack = 1'b1; mem_rdata = RD ^ LW'(g + 1);
      @(negedge clk); mem_ack = 1'b0;
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    total++;
    if (order != "IDID") begin
      bad++;
      $display("FAIL grant_order: got %s expected IDID", order);
    end
    // watchdog abort on a D read that is never acknowledged
    @(negedge clk); dreq_valid = 1'b1; dreq_write = 1'b0; dreq_addr = 32'h0000_4000;
    @(negedge clk); dreq_valid = 1'b0;
    chk("to_ready", LW'(dreq_ready), LW'(1'b1));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("to_req_held", LW'(mem_req), LW'(1'b1));
    end
    @(negedge clk);
    chk("to_req_drop", LW'(mem_req), '0);
    chk("to_err", LW'(timeout_err), LW'(1'b1));
    chk("to_rsp_valid", LW'(drsp_valid), LW'(1'b1));
    chk("to_rsp_data", drsp_data, '0);
    @(negedge clk);
    chk("to_err_pulse", LW'(timeout_err), '0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
